// File: rtl/sync_fifo_ctrl_if.sv
// Handshake bundle for sync_fifo_ctrl. The producer/consumer side takes the master modport.
// The FIFO takes the slave modport.
interface sync_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEVEL_W    = 7
);
  logic                  w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  r_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [LEVEL_W-1:0]    level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_en, data_in, r_en, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  w_en, data_in, r_en, clr_err,
    output data_out, full, empty, almost_full, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through read mode,
// fill level, almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_ctrl #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DEPTH - 4,
  parameter int AE_LEVEL   = 4
) (
  input logic              clk,
  input logic              rst_n,
  sync_fifo_ctrl_if.slave  fifo_if
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W-1:0] LastIdx  = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] DepthLvl = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AfLvl    = LVL_W'(AF_LEVEL);
  localparam logic [LVL_W-1:0] AeLvl    = LVL_W'(AE_LEVEL);

  if (DEPTH < 2) begin : g_chk_depth
    $fatal(1, "sync_fifo_ctrl: DEPTH must be >= 2");
  end
  if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_chk_levels
    $fatal(1, "sync_fifo_ctrl: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [PTR_W-1:0]      r_wptr, r_rptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_full, r_empty, r_af, r_ae;
  logic                  r_ovf, r_unf;
  logic [DATA_WIDTH-1:0] r_dout;

  logic                  w_wr_acc, w_rd_acc;
  logic [PTR_W-1:0]      w_wptr_nxt, w_rptr_nxt;
  logic [LVL_W-1:0]      w_level_nxt;
  logic                  w_ovf_nxt, w_unf_nxt;
  logic [DATA_WIDTH-1:0] w_dout_nxt;

  always_comb begin
    w_wr_acc = fifo_if.w_en && !r_full;
    w_rd_acc = fifo_if.r_en && !r_empty;

    w_wptr_nxt = r_wptr;
    if (w_wr_acc) begin
      w_wptr_nxt = (r_wptr == LastIdx) ? '0 : r_wptr + PTR_W'(1);
    end

    w_rptr_nxt = r_rptr;
    if (w_rd_acc) begin
      w_rptr_nxt = (r_rptr == LastIdx) ? '0 : r_rptr + PTR_W'(1);
    end

    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_level_nxt = r_level + LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase

    // A new set condition beats a simultaneous clear.
    w_ovf_nxt = (fifo_if.w_en && r_full) || (r_ovf && !fifo_if.clr_err);
    w_unf_nxt = (fifo_if.r_en && r_empty) || (r_unf && !fifo_if.clr_err);

    w_dout_nxt = r_dout;
    if (FWFT == 0) begin
      if (w_rd_acc) w_dout_nxt = r_mem[r_rptr];
    end else begin
      // Keep the head presented: on a pop, the next entry is either already in memory
      // or is the word being written this very cycle.
      if (w_rd_acc) begin
        if (r_level > LVL_W'(1)) begin
          w_dout_nxt = r_mem[w_rptr_nxt];
        end else if (w_wr_acc) begin
          w_dout_nxt = fifo_if.data_in;
        end
      end else if (w_wr_acc && r_empty) begin
        w_dout_nxt = fifo_if.data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= fifo_if.data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == DepthLvl);
      r_empty <= (w_level_nxt == '0);
      r_af    <= (w_level_nxt >= AfLvl);
      r_ae    <= (w_level_nxt <= AeLvl);
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
      r_dout  <= w_dout_nxt;
    end
  end

  assign fifo_if.data_out     = r_dout;
  assign fifo_if.full         = r_full;
  assign fifo_if.empty        = r_empty;
  assign fifo_if.almost_full  = r_af;
  assign fifo_if.almost_empty = r_ae;
  assign fifo_if.level        = r_level;
  assign fifo_if.overflow     = r_ovf;
  assign fifo_if.underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl: three instances (DEPTH 6 std, DEPTH 8 std, DEPTH 16 FWFT)
// share one stimulus/observation path selected by sel.
module tb_sync_fifo_ctrl;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .LEVEL_W(3)) if_a ();
  sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .LEVEL_W(4)) if_b ();
  sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .LEVEL_W(5)) if_c ();

  sync_fifo_ctrl #(.DEPTH(6), .DATA_WIDTH(DW), .FWFT(0), .AF_LEVEL(5), .AE_LEVEL(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .fifo_if(if_a)
  );
  sync_fifo_ctrl #(.DEPTH(8), .DATA_WIDTH(DW), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_if(if_b)
  );
  sync_fifo_ctrl #(.DEPTH(16), .DATA_WIDTH(DW), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .fifo_if(if_c)
  );

  int          sel = 0;
  logic        w_en = 1'b0, r_en = 1'b0, clr_err = 1'b0;
  logic [7:0]  din = '0;

  assign if_a.w_en = w_en && (sel == 0);
  assign if_a.r_en = r_en && (sel == 0);
  assign if_a.clr_err = clr_err && (sel == 0);
  assign if_a.data_in = din;
  assign if_b.w_en = w_en && (sel == 1);
  assign if_b.r_en = r_en && (sel == 1);
  assign if_b.clr_err = clr_err && (sel == 1);
  assign if_b.data_in = din;
  assign if_c.w_en = w_en && (sel == 2);
  assign if_c.r_en = r_en && (sel == 2);
  assign if_c.clr_err = clr_err && (sel == 2);
  assign if_c.data_in = din;

  logic [7:0] o_dout;
  logic [4:0] o_level;
  logic       o_full, o_empty, o_af, o_ae, o_ovf, o_unf;

  always_comb begin
    o_dout = if_c.data_out; o_level = if_c.level; o_full = if_c.full; o_empty = if_c.empty;
    o_af = if_c.almost_full; o_ae = if_c.almost_empty; o_ovf = if_c.overflow;
    o_unf = if_c.underflow;
    if (sel == 0) begin
      o_dout = if_a.data_out; o_level = {2'b00, if_a.level}; o_full = if_a.full;
      o_empty = if_a.empty; o_af = if_a.almost_full; o_ae = if_a.almost_empty;
      o_ovf = if_a.overflow; o_unf = if_a.underflow;
    end else if (sel == 1) begin
      o_dout = if_b.data_out; o_level = {1'b0, if_b.level}; o_full = if_b.full;
      o_empty = if_b.empty; o_af = if_b.almost_full; o_ae = if_b.almost_empty;
      o_ovf = if_b.overflow; o_unf = if_b.underflow;
    end
  end

  // Reference model: contents queue plus per-instance flags and presented data.
  int         depth_t [3] = '{6, 8, 16};
  int         af_t    [3] = '{5, 6, 12};
  int         ae_t    [3] = '{1, 2, 4};
  bit         fwft_t  [3] = '{1'b0, 1'b0, 1'b1};
  logic [7:0] sb [$];
  bit         m_ovf  [3] = '{1'b0, 1'b0, 1'b0};
  bit         m_unf  [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] m_dout [3] = '{8'h00, 8'h00, 8'h00};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (dut %0d): got 0x%0h expected 0x%0h", tag, sel, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int lv;
    lv = sb.size();
    check({tag, " level"}, 32'(o_level), 32'(lv));
    check({tag, " full"}, 32'(o_full), 32'(lv == depth_t[sel]));
    check({tag, " empty"}, 32'(o_empty), 32'(lv == 0));
    check({tag, " almost_full"}, 32'(o_af), 32'(lv >= af_t[sel]));
    check({tag, " almost_empty"}, 32'(o_ae), 32'(lv <= ae_t[sel]));
    check({tag, " overflow"}, 32'(o_ovf), 32'(m_ovf[sel]));
    check({tag, " underflow"}, 32'(o_unf), 32'(m_unf[sel]));
    check({tag, " data_out"}, 32'(o_dout), 32'(m_dout[sel]));
  endtask

  task automatic cyc(input logic we, input logic [7:0] d, input logic re, input logic ce,
                     input string tag);
    int lv;
    bit wa, ra;
    logic [7:0] e;
    lv = sb.size();
    wa = we && (lv != depth_t[sel]);
    ra = re && (lv != 0);
    w_en = we; din = d; r_en = re; clr_err = ce;
    @(posedge clk);
    #1;
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
    m_ovf[sel] = (we && lv == depth_t[sel]) || (m_ovf[sel] && !ce);
    m_unf[sel] = (re && lv == 0) || (m_unf[sel] && !ce);
    if (ra) begin
      e = sb.pop_front();
      if (!fwft_t[sel]) m_dout[sel] = e;
    end
    if (wa) sb.push_back(d);
    if (fwft_t[sel] && sb.size() != 0) m_dout[sel] = sb[0];
    check_state(tag);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1 check_state("reset");
    end
    @(posedge clk);
    #1;

    // Non-power-of-2 depth, two full/empty rounds to cross the pointer wrap.
    sel = 0;
    repeat (2) begin
      for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "a_wr");
      for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "a_rd");
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "a_fill");
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'hD0 + i), 1'b1, 1'b0, "a_stream");
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "a_drain");

    // Overflow / underflow / clear, then sustained streaming at level 4.
    sel = 1;
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "b_fill");
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, "b_ovf");
    cyc(1'b0, 8'h00, 1'b0, 1'b1, "b_clr_ovf");
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "b_drain");
    cyc(1'b0, 8'h00, 1'b1, 1'b0, "b_unf");
    cyc(1'b0, 8'h00, 1'b1, 1'b1, "b_set_wins");
    cyc(1'b0, 8'h00, 1'b0, 1'b1, "b_clr_unf");
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, "b_fill4");
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, "b_stream");
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "b_drain4");
    cyc(1'b1, 8'h99, 1'b1, 1'b0, "b_empty_both");
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, "b_refill");
    cyc(1'b1, 8'hBB, 1'b1, 1'b0, "b_full_both");
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "b_drain7");
    cyc(1'b0, 8'h00, 1'b0, 1'b1, "b_clr_all");

    // FWFT head presentation, then threshold sweep 0 -> 16 -> 0.
    sel = 2;
    cyc(1'b1, 8'h55, 1'b0, 1'b0, "c_fwft_wr");
    cyc(1'b0, 8'h00, 1'b0, 1'b0, "c_fwft_idle");
    cyc(1'b0, 8'h00, 1'b1, 1'b0, "c_fwft_rd");
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, "c_fill");
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "c_drain");

    // Asynchronous reset between edges with 7 entries stored.
    sel = 1;
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, "d_fill");
    #1 rst_n = 1'b0;
    sb.delete();
    for (int s = 0; s < 3; s++) begin
      m_ovf[s] = 1'b0; m_unf[s] = 1'b0; m_dout[s] = 8'h00;
    end
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1 check_state("d_async_rst");
    end
    rst_n = 1'b1;
    sel = 1;
    cyc(1'b1, 8'h77, 1'b0, 1'b0, "d_wr");
    cyc(1'b0, 8'h00, 1'b1, 1'b0, "d_rd");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock, parameterised FIFO. It is the same-domain successor to the team's dual-clock FIFO, for paths where producer and consumer share one clock.
- Adds several features:
  - arbitrary (non-power-of-2) depth
  - selectable standard / first-word-fall-through (FWFT) read mode
  - fill-level output
  - programmable almost-full / almost-empty thresholds
  - sticky overflow/underflow error flags
- Sits between bus-side producers and datapath consumers inside one clock domain.

Parameters:
- DEPTH, 64, number of entries; any integer >= 2.
- DATA_WIDTH, 32, width of each entry in bits.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-4, almost_full asserts when level >= AF_LEVEL.
- AE_LEVEL, 4, almost_empty asserts when level <= AE_LEVEL.

Ports:
- clk  in  1  the single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- w_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- r_en  in  1  read request (in FWFT mode, pop/acknowledge of the head entry).
- clr_err  in  1  synchronous clear of the sticky error flags.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AF_LEVEL.
- almost_empty  out  1  level <= AE_LEVEL.
- level  out  $clog2(DEPTH+1)  current number of stored entries.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - write pointer, read pointer, level, overflow, underflow, data_out all go to 0.
  - Outputs after reset: empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored entries immediately.
- Acceptance (uses flag values at the current edge; no same-cycle bypass):
  - write is accepted iff w_en && !full.
  - read is accepted iff r_en && !empty.
- Accepted write: mem[wptr] <= data_in; wptr advances; wptr wraps from DEPTH-1 to 0 by explicit compare, with no power-of-2 assumption.
- Accepted read: rptr advances, wrapping the same way as wptr.
- level update (registered):
  - write only: level + 1.
  - read only: level - 1.
  - both accepted: unchanged.
- Flags full, empty, almost_full, almost_empty are registered (or decoded from the registered level) and always consistent with level in the same cycle.
- Simultaneous w_en && r_en:
  - 0 < level < DEPTH: both accepted; level unchanged.
  - empty: write accepted, read rejected; underflow sets; level becomes 1.
  - full: read accepted, write rejected; overflow sets; level becomes DEPTH-1.
- Error flags:
  - overflow sets on any cycle with w_en && full.
  - underflow sets on any cycle with r_en && empty.
  - Both hold until clr_err.
  - If clr_err and a set condition occur in the same cycle, set wins.
- Standard mode (FWFT=0):
  - data_out <= mem[rptr] on the edge that accepts a read, so data is visible one cycle after r_en.
  - data_out holds its value when no read is accepted.
- FWFT mode (FWFT=1):
  - While empty=0, data_out continuously presents mem[rptr].
  - A write into an empty FIFO makes data visible, with empty=0, one cycle after the write.
  - An accepted read presents the next entry on the following cycle.
  - While empty=1, data_out holds its last value (0 after reset).
- Parameter checks at elaboration (fatal error if violated):
  - DEPTH >= 2
  - 0 <= AE_LEVEL < AF_LEVEL <= DEPTH
- Throughput: one write and one read per cycle sustained; no bubbles at pointer wrap.

Test Plan:
- DEPTH=6 (non-power-of-2), FWFT=0: write 0x10..0x15, then read 6 times.
  - full=1 and level=6 after 6th write.
  - data_out = 0x10..0x15, each one cycle after r_en.
  - empty=1 at end.
  - Repeat twice to cross the pointer wrap.
- DEPTH=8, full: assert w_en with data 0xAA while full.
  - overflow=1, level stays 8, 0xAA is never read out.
  - Pulse clr_err: overflow=0.
  - Assert r_en when empty: underflow=1.
- DEPTH=8, level=4: w_en && r_en every cycle for 20 cycles.
  - level stays 4; output order preserved.
  - At empty with both asserted: level goes to 1 and underflow=1.
- FWFT=1: write 0x55 into empty FIFO.
  - Next cycle: empty=0, data_out=0x55 with no r_en.
  - r_en one cycle: empty=1; data_out holds 0x55.
- DEPTH=16, AF_LEVEL=12, AE_LEVEL=4: fill 0->16 then drain.
  - almost_empty clears at level 5.
  - almost_full sets at level 12.
  - Both flags toggle back at the same levels on drain.
- Reset mid-stream: level=7, deassert rst_n asynchronously between edges.
  - level=0, empty=1, data_out=0, error flags=0 immediately.
  - After release, the first write/read pair returns the new data.
